// File: rtl/chaos_rng_stream_if.sv
// chaos_rng_stream_if: valid/ready stream port carrying whitened RNG words and FIFO occupancy.
interface chaos_rng_stream_if #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 8
);
    logic [WIDTH-1:0]            rnd_data;
    logic                        rnd_valid;
    logic                        rnd_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    modport master (output rnd_data, rnd_valid, fifo_level, input rnd_ready);
    modport slave  (input rnd_data, rnd_valid, fifo_level, output rnd_ready);
endinterface

// File: rtl/chaos_rng_stream.sv
// chaos_rng_stream: warm-up sequenced 3-D multi-scroll chaotic RNG with whitening and a stream FIFO.
// The stuck-word health check is compiled in with CHAOS_RNG_STUCK_DETECT_EN.
module chaos_rng_stream #(
    parameter int WIDTH      = 32,
    parameter int SHIFT      = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int WARMUP     = 16,
    parameter int REP_LIMIT  = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   x_seed,
    input  logic [WIDTH-1:0]   y_seed,
    input  logic [WIDTH-1:0]   z_seed,
    input  logic [23:0]        scroll_cfg,
    input  logic [2:0]         ch_en,
    input  logic               run,
    output logic               busy,
    output logic               health_fail,
    chaos_rng_stream_if.master strm
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(WARMUP + 1);

`ifdef CHAOS_RNG_STUCK_DETECT_EN
    typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN} state_t;
`endif

    state_t                  state;
    logic signed [WIDTH-1:0] x, y, z, xo, yo, zo, d1, d, xn, yn, zn;
    logic [WIDTH-1:0]        w;
    logic [WIDTH-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [LW-1:0]           level;
    logic [CW-1:0]           cnt;
    logic                    pop, adv, push;
    logic                    unused_cfg;

    // Multi-scroll fold of the top six bits against the lower/upper breakpoints
    function automatic logic [WIDTH-1:0] scroll(input logic [WIDTH-1:0] f, input logic [2:0] u, input logic [3:0] l);
        logic [5:0] a, b;
        a = f[WIDTH-1 -: 6] - {l[3], l, 1'b1};
        b = f[WIDTH-1 -: 6] - {u[2], u[2], u, 1'b1};
        return {a[5] ? a : b[5] ? ~{6{f[WIDTH-6]}} : b, f[WIDTH-7:0]};
    endfunction

    // Scroll shaping, next-state arithmetic and whitening of the current state
    always_comb begin
        xo = ch_en[0] ? scroll(x, scroll_cfg[6:4], scroll_cfg[3:0]) : x;
        yo = ch_en[1] ? scroll(y, scroll_cfg[14:12], scroll_cfg[11:8]) : y;
        zo = ch_en[2] ? scroll(z, scroll_cfg[22:20], scroll_cfg[19:16]) : z;
        d1 = xo + yo + zo;
        d  = d1 - (d1 >>> 4);
        xn = x + (yo >>> SHIFT);
        yn = y + (zo >>> SHIFT);
        zn = z - (d >>> SHIFT);
        w  = x ^ {y[WIDTH/2-1:0], y[WIDTH-1:WIDTH/2]} ^ z;
    end

    // A reseed discards any same-cycle pop; the core only advances when the FIFO can take the word
    assign pop        = strm.rnd_valid && strm.rnd_ready && !seed_load;
    assign adv        = state == S_RUN && run && !seed_load && (level < LW'(FIFO_DEPTH) || pop);
    assign unused_cfg = ^{scroll_cfg[23], scroll_cfg[15], scroll_cfg[7]};

`ifdef CHAOS_RNG_STUCK_DETECT_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    logic [RW-1:0]    rep, rep_nx;
    logic [WIDTH-1:0] last_w;
    logic             hit;

    assign rep_nx = (rep != '0 && w == last_w) ? rep + 1'b1 : RW'(1);
    assign hit    = adv && rep_nx == RW'(REP_LIMIT);
    assign push   = adv && !hit;

    // Consecutive-repeat tracker and sticky health fault
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || seed_load) begin
            rep         <= '0;
            last_w      <= '0;
            health_fail <= 1'b0;
        end else if (hit) begin
            health_fail <= 1'b1;
        end else if (push) begin
            rep    <= rep_nx;
            last_w <= w;
        end
    end
`else
    logic unused_rep;
    assign push        = adv;
    assign health_fail = 1'b0;
    assign unused_rep  = REP_LIMIT > 0;
`endif

    // Sequencer: seed load, warm-up iterations, then iterate once per pushed word
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            cnt   <= '0;
        end else if (seed_load) begin
            state <= S_WARM;
            x     <= x_seed;
            y     <= y_seed;
            z     <= z_seed;
            cnt   <= '0;
        end else if (state == S_WARM) begin
            x   <= xn;
            y   <= yn;
            z   <= zn;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WARMUP - 1))
                state <= S_RUN;
        end else if (push) begin
            x <= xn;
            y <= yn;
            z <= zn;
        end
`ifdef CHAOS_RNG_STUCK_DETECT_EN
        else if (hit) begin
            state <= S_FAULT;
        end
`endif
    end

    // FIFO pointers and occupancy; a reseed flushes pending words
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || seed_load) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // FIFO storage, read as first-word fall-through
    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem[wr_ptr] <= w;
    end

    assign strm.rnd_data   = mem[rd_ptr];
    assign strm.rnd_valid  = level != '0;
    assign strm.fifo_level = level;
    assign busy            = state == S_WARM;
endmodule

// File: tb/tb_chaos_rng_stream.sv
// tb_chaos_rng_stream: 32- and 16-bit instances driven in lockstep against a queue-based reference stream.
module tb_chaos_rng_stream;
    typedef longint unsigned u64;
    localparam int SH = 3;
    localparam int DEPTH = 8;
    localparam int WU = 16;

    logic        clk = 0;
    logic        rst, sl, run, rdy;
    logic [31:0] xs, ys, zs;
    logic [23:0] cfg;
    logic [2:0]  en;
    logic        busy32, busy16, hf32, hf16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chaos_rng_stream_if #(.WIDTH(32), .FIFO_DEPTH(DEPTH)) s32();
    chaos_rng_stream_if #(.WIDTH(16), .FIFO_DEPTH(DEPTH)) s16();
    assign s32.rnd_ready = rdy;
    assign s16.rnd_ready = rdy;

    chaos_rng_stream #(.WIDTH(32)) u32 (
        .wb_clk_i(clk), .wb_rst_i(rst), .seed_load(sl),
        .x_seed(xs), .y_seed(ys), .z_seed(zs),
        .scroll_cfg(cfg), .ch_en(en), .run(run),
        .busy(busy32), .health_fail(hf32), .strm(s32)
    );

    chaos_rng_stream #(.WIDTH(16)) u16 (
        .wb_clk_i(clk), .wb_rst_i(rst), .seed_load(sl),
        .x_seed(xs[15:0]), .y_seed(ys[15:0]), .z_seed(zs[15:0]),
        .scroll_cfg(cfg), .ch_en(en), .run(run),
        .busy(busy16), .health_fail(hf16), .strm(s16)
    );

    // Reference: per-width chaotic state, a mode number and queues of expected words
    u64 mx[2], my[2], mz[2];
    int nw[2] = '{32, 16};
    u64 q32[$], q16[$];
    int qi[$];
    int mode, cnt, pidx, rep, rec, nrec;
    bit hf;
    u64 last;
    u64 first[64];

    task automatic chk(input string tag, input u64 got, input u64 exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic u64 msk(int n);
        return (u64'(1) << n) - 1;
    endfunction

    function automatic u64 sra(u64 v, int n, int s);
        longint sv;
        sv = longint'(v) - (v[n-1] ? longint'(u64'(1) << n) : 0);
        return u64'(sv >>> s) & msk(n);
    endfunction

    function automatic u64 scr(u64 f, int n, int u, int l);
        int h, a, b, uv, lv, top;
        h   = int'((f >> (n - 6)) & 63);
        uv  = u >= 4 ? u - 8 : u;
        lv  = l >= 8 ? l - 16 : l;
        a   = (h - 2 * lv - 1) & 63;
        b   = (h - 2 * uv - 1) & 63;
        top = a >= 32 ? a : b >= 32 ? ((h & 1) != 0 ? 0 : 63) : b;
        return (u64'(top) << (n - 6)) | (f & msk(n - 6));
    endfunction

    function automatic u64 whiten(int i);
        int n = nw[i];
        u64 rot = ((my[i] << (n / 2)) | (my[i] >> (n / 2))) & msk(n);
        return mx[i] ^ rot ^ mz[i];
    endfunction

    task automatic step(input int i);
        int n;
        u64 m, xo, yo, zo, d1, d, nx, ny, nz;
        n  = nw[i];
        m  = msk(n);
        xo = en[0] ? scr(mx[i], n, int'(cfg[6:4]), int'(cfg[3:0])) : mx[i];
        yo = en[1] ? scr(my[i], n, int'(cfg[14:12]), int'(cfg[11:8])) : my[i];
        zo = en[2] ? scr(mz[i], n, int'(cfg[22:20]), int'(cfg[19:16])) : mz[i];
        d1 = (xo + yo + zo) & m;
        d  = (d1 - sra(d1, n, 4)) & m;
        nx = (mx[i] + sra(yo, n, SH)) & m;
        ny = (my[i] + sra(zo, n, SH)) & m;
        nz = (mz[i] - sra(d, n, SH)) & m;
        mx[i] = nx;
        my[i] = ny;
        mz[i] = nz;
    endtask

    // What the next clock edge does, given the inputs now applied (modes: 0 idle, 1 warm, 2 run, 3 fault)
    task automatic model_edge();
        bit pop, push;
        u64 w0, w1;
`ifdef CHAOS_RNG_STUCK_DETECT_EN
        int rn;
`endif
        if (rst || sl) begin
            mode = rst ? 0 : 1;
            cnt  = 0;
            pidx = 0;
            hf   = 0;
            rep  = 0;
            q32.delete();
            q16.delete();
            qi.delete();
            if (!rst) begin
                mx[0] = xs; my[0] = ys; mz[0] = zs;
                mx[1] = xs & 16'hFFFF; my[1] = ys & 16'hFFFF; mz[1] = zs & 16'hFFFF;
            end
            return;
        end
        pop  = q32.size() != 0 && rdy;
        push = 0;
        if (mode == 1) begin
            step(0);
            step(1);
            cnt++;
            if (cnt == WU) mode = 2;
        end else if (mode == 2 && run && (q32.size() < DEPTH || pop)) begin
            w0 = whiten(0);
            w1 = whiten(1);
            push = 1;
`ifdef CHAOS_RNG_STUCK_DETECT_EN
            rn = (rep != 0 && w0 == last) ? rep + 1 : 1;
            if (rn == 4) begin
                push = 0;
                mode = 3;
                hf   = 1;
            end else begin
                rep  = rn;
                last = w0;
            end
`endif
            if (push) begin
                step(0);
                step(1);
            end
        end
        if (pop) begin
            void'(q32.pop_front());
            void'(q16.pop_front());
            void'(qi.pop_front());
        end
        if (push) begin
            q32.push_back(w0);
            q16.push_back(w1);
            qi.push_back(pidx);
            if (rec == 1 && pidx < 64) begin
                first[pidx] = w0;
                nrec = pidx + 1;
            end
            pidx++;
        end
    endtask

    // Compare the settled outputs, advance the reference, then take one clock edge
    task automatic cyc();
        chk("valid32", s32.rnd_valid, q32.size() != 0);
        chk("valid16", s16.rnd_valid, q16.size() != 0);
        chk("level32", s32.fifo_level, q32.size());
        chk("level16", s16.fifo_level, q16.size());
        chk("busy", {busy32, busy16}, mode == 1 ? 2'b11 : 2'b00);
        chk("health", {hf32, hf16}, hf ? 2'b11 : 2'b00);
        if (q32.size() != 0) begin
            chk("data32", s32.rnd_data, q32[0]);
            chk("data16", s16.rnd_data, q16[0]);
            if (rec == 2 && rdy && qi[0] < nrec)
                chk("restart", s32.rnd_data, first[qi[0]]);
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; sl = 0; run = 1; rdy = 0;
        xs = 0; ys = 0; zs = 0; cfg = 0; en = 0;
        mode = 0; cnt = 0; pidx = 0; rep = 0; rec = 0; nrec = 0; hf = 0; last = 0;
        @(posedge clk);
        #1;
        repeat (2) cyc();
        rst = 0;
        repeat (6) cyc();

        // Warm-up latency and first words
        xs = 32'hDE78D681; ys = 32'hFEEE4640; zs = 32'hFE8E511B;
        cfg = 24'h4D4C4B; en = 3'd7; rec = 1;
        sl = 1;
        cyc();
        sl = 0;
        repeat (WU) cyc();
        chk("first_not_yet", s32.rnd_valid, 0);
        cyc();
        chk("first_valid", s32.rnd_valid, 1);

        // Backpressure until full, then streaming at full occupancy
        repeat (12) cyc();
        chk("full_level", s32.fifo_level, DEPTH);
        rdy = 1;
        repeat (20) cyc();
        chk("stream_level", s32.fifo_level, DEPTH);

        // Drain to five with the core frozen, then reseed during a pop
        run = 0;
        repeat (3) cyc();
        chk("pre_reseed_level", s32.fifo_level, 5);
        run = 1;
        rec = 2;
        sl = 1;
        cyc();
        sl = 0;
        chk("reseed_level", s32.fifo_level, 0);
        chk("reseed_busy", busy32, 1);
        repeat (45) cyc();
        rec = 0;

        // Degenerate configuration: all-zero state
        xs = 0; ys = 0; zs = 0; en = 0; rdy = 0;
        sl = 1;
        cyc();
        sl = 0;
        repeat (WU + 20) cyc();
`ifdef CHAOS_RNG_STUCK_DETECT_EN
        chk("stuck_health", hf32, 1);
        chk("stuck_level", s32.fifo_level, 3);
`else
        chk("zero_health", hf32, 0);
        chk("zero_level", s32.fifo_level, DEPTH);
`endif
        chk("zero_word", s32.rnd_data, 0);

        // Randomized handshake, run gating and occasional reseeds
        xs = $urandom; ys = $urandom; zs = $urandom;
        cfg = 24'($urandom); en = 3'($urandom);
        sl = 1;
        cyc();
        sl = 0;
        for (int i = 0; i < 10000; i++) begin
            rdy = $urandom_range(0, 2) != 0;
            run = $urandom_range(0, 7) != 0;
            sl  = $urandom_range(0, 699) == 0;
            if (sl) begin
                xs = $urandom; ys = $urandom; zs = $urandom;
                cfg = 24'($urandom); en = 3'($urandom);
            end
            cyc();
            sl = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
